// File: rtl/slot_alloc.sv
// Round-robin slot allocator over a W-entry occupancy vector with a release port.
// Define SLOT_ALLOC_CHECK_EN to drop illegal frees and raise a sticky err_o.
module slot_alloc #(
    parameter int W = 32,
    localparam int IW = $clog2(W),
    localparam int CW = $clog2(W) + 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          alloc_req_i,
    output logic          alloc_rdy_o,
    output logic [IW-1:0] alloc_id_o,
    input  logic          free_vld_i,
    input  logic [IW-1:0] free_id_i,
    output logic [W-1:0]  occ_o,
    output logic [CW-1:0] count_o,
    output logic          full_o,
    output logic          empty_o,
    output logic          err_o
);

    logic [W-1:0]  occ;
    logic [W-1:0]  occ_next;
    logic [IW-1:0] ptr;
    logic [IW-1:0] cand;
    logic [IW-1:0] search_id;
    logic          found;
    logic [CW-1:0] count;
    logic [CW-1:0] count_next;
    logic          full;
    logic          empty;
    logic          grant;
    logic          free_dec;

    // Circular search from ptr; IW-bit addition wraps because W is a power of two.
    always_comb begin
        search_id = ptr;
        found     = 1'b0;
        cand      = ptr;
        for (int k = 0; k < W; k++) begin
            cand = ptr + IW'(k);
            if (!found && !occ[cand]) begin
                search_id = cand;
                found     = 1'b1;
            end
        end
    end

    assign alloc_id_o  = search_id;
    assign alloc_rdy_o = ~full & ~rst_i;
    assign grant       = alloc_req_i & alloc_rdy_o;

`ifdef SLOT_ALLOC_CHECK_EN
    logic free_ok;
    logic free_bad;
    logic err;

    // A legal free names an occupied slot that is not the one being granted.
    assign free_ok  = free_vld_i & occ[free_id_i] & ~(grant & (free_id_i == alloc_id_o));
    assign free_bad = free_vld_i & ~free_ok;
    assign free_dec = free_ok;

    always_comb begin
        occ_next = occ;
        if (free_ok) begin
            occ_next[free_id_i] = 1'b0;
        end
        if (grant) begin
            occ_next[alloc_id_o] = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err <= 1'b0;
        end else if (free_bad) begin
            err <= 1'b1;
        end
    end

    assign err_o = err;
`else
    assign free_dec = free_vld_i & occ[free_id_i];

    // Grant is applied after the clear so the counter and vector never disagree.
    always_comb begin
        occ_next = occ;
        if (free_vld_i) begin
            occ_next[free_id_i] = 1'b0;
        end
        if (grant) begin
            occ_next[alloc_id_o] = 1'b1;
        end
    end

    assign err_o = 1'b0;
`endif

    assign count_next = count + CW'(grant) - CW'(free_dec);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            occ   <= '0;
            ptr   <= '0;
            count <= '0;
            full  <= 1'b0;
            empty <= 1'b1;
        end else begin
            occ   <= occ_next;
            count <= count_next;
            full  <= (count_next == CW'(W));
            empty <= (count_next == '0);
            if (grant) begin
                ptr <= alloc_id_o + IW'(1);
            end
        end
    end

    assign occ_o   = occ;
    assign count_o = count;
    assign full_o  = full;
    assign empty_o = empty;

endmodule

// File: tb/tb_slot_alloc.sv
// Bench for slot_alloc (W=8): directed scenarios plus randomized traffic
// compared against an array-based reference model of the allocation rules.
module tb_slot_alloc;
    localparam int W = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       alloc_req;
    logic       alloc_rdy;
    logic [2:0] alloc_id;
    logic       free_vld;
    logic [2:0] free_id;
    logic [7:0] occ;
    logic [3:0] count;
    logic       full;
    logic       empty;
    logic       err;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] m_occ;
    int         m_ptr;
    logic       m_err;
    logic       exp_err_bad_free;

    always #5 clk = ~clk;

    slot_alloc #(.W(W)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .alloc_req_i(alloc_req),
        .alloc_rdy_o(alloc_rdy),
        .alloc_id_o (alloc_id),
        .free_vld_i (free_vld),
        .free_id_i  (free_id),
        .occ_o      (occ),
        .count_o    (count),
        .full_o     (full),
        .empty_o    (empty),
        .err_o      (err)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // First free slot scanning ptr, ptr+1, ... modulo W; -1 when none is free.
    function automatic int model_id();
        for (int k = 0; k < W; k++) begin
            if (!m_occ[(m_ptr + k) % W]) return (m_ptr + k) % W;
        end
        return -1;
    endfunction

    task automatic cycle(input logic r, input logic req, input logic fv, input logic [2:0] fid);
        int   eid;
        logic erdy;
        logic grant;
        logic hit_grant;
        rst       = r;
        alloc_req = req;
        free_vld  = fv;
        free_id   = fid;
        #1;
        eid  = model_id();
        erdy = !r && ($countones(m_occ) < W);
        check_val("rdy", 32'(alloc_rdy), 32'(erdy));
        if (erdy) check_val("id", 32'(alloc_id), 32'(eid));
        @(posedge clk);
        #1;
        if (r) begin
            m_occ = '0;
            m_ptr = 0;
            m_err = 1'b0;
        end else begin
            grant     = req && erdy;
            hit_grant = grant && (fid == eid[2:0]);
`ifdef SLOT_ALLOC_CHECK_EN
            if (fv && !(m_occ[fid] && !hit_grant)) m_err = 1'b1;
            if (fv && m_occ[fid] && !hit_grant) m_occ[fid] = 1'b0;
`else
            if (fv && !hit_grant) m_occ[fid] = 1'b0;
`endif
            if (grant) begin
                m_occ[eid] = 1'b1;
                m_ptr      = (eid + 1) % W;
            end
        end
        check_val("occ", 32'(occ), 32'(m_occ));
        check_val("count", 32'(count), 32'($countones(m_occ)));
        check_val("full", 32'(full), 32'($countones(m_occ) == W));
        check_val("empty", 32'(empty), 32'($countones(m_occ) == 0));
        check_val("err", 32'(err), 32'(m_err));
    endtask

    initial begin
        m_occ = '0;
        m_ptr = 0;
        m_err = 1'b0;
`ifdef SLOT_ALLOC_CHECK_EN
        exp_err_bad_free = 1'b1;
`else
        exp_err_bad_free = 1'b0;
`endif

        // Reset, then fill all 8 slots in order
        cycle(1, 0, 0, 0);
        cycle(1, 1, 0, 0);
        for (int i = 0; i < W; i++) begin
            check_val("fill_id", 32'(alloc_id), 32'(i));
            cycle(0, 1, 0, 0);
        end
        check_val("fill_full", 32'(full), 32'd1);
        check_val("fill_rdy", 32'(alloc_rdy), 32'd0);
        check_val("fill_count", 32'(count), 32'd8);

        // Full, release slot 3 while requesting: no grant this cycle
        cycle(0, 1, 1, 3);
        check_val("free3_rdy", 32'(alloc_rdy), 32'd1);
        check_val("free3_id", 32'(alloc_id), 32'd3);

        // occ=0001_1111, ptr=5, grant 5 with simultaneous free of 1
        cycle(1, 0, 0, 0);
        for (int i = 0; i < 5; i++) cycle(0, 1, 0, 0);
        cycle(0, 1, 1, 1);
        check_val("mix_occ", 32'(occ), 32'h3D);
        check_val("mix_count", 32'(count), 32'd5);
        check_val("mix_next_id", 32'(alloc_id), 32'd6);

        // ptr=7 with slot 7 busy and slot 0 free: search wraps to 0
        cycle(1, 0, 0, 0);
        for (int i = 0; i < W; i++) cycle(0, 1, 0, 0);
        cycle(0, 0, 1, 6);
        cycle(0, 1, 1, 0);
        check_val("wrap_id", 32'(alloc_id), 32'd0);
        check_val("wrap_occ", 32'(occ), 32'hFE);

        // Free of an unoccupied slot
        cycle(1, 0, 0, 0);
        cycle(0, 0, 1, 2);
        check_val("badfree_occ", 32'(occ), 32'h00);
        check_val("badfree_err", 32'(err), 32'(exp_err_bad_free));
        cycle(0, 1, 0, 0);
        cycle(0, 0, 0, 0);
        check_val("badfree_err_sticky", 32'(err), 32'(exp_err_bad_free));

        // Reset mid-operation with four slots held
        cycle(1, 0, 0, 0);
        for (int i = 0; i < 4; i++) cycle(0, 1, 0, 0);
        check_val("pre_rst_count", 32'(count), 32'd4);
        cycle(1, 1, 0, 0);
        rst = 1'b0;
        #1;
        check_val("rst_occ", 32'(occ), 32'h00);
        check_val("rst_empty", 32'(empty), 32'd1);
        check_val("rst_rdy", 32'(alloc_rdy), 32'd1);
        check_val("rst_id", 32'(alloc_id), 32'd0);
        check_val("rst_err", 32'(err), 32'd0);

        // Randomized traffic
        for (int n = 0; n < 500; n++) begin
            logic       r;
            logic       rq;
            logic       fv;
            logic [2:0] fid;
            int         eid;
            logic       gr;
            r   = ($urandom_range(0, 63) == 0);
            rq  = 1'($urandom_range(0, 1));
            fv  = 1'b0;
            fid = 3'($urandom_range(0, 7));
            eid = model_id();
            gr  = rq && !r && (eid >= 0);
            if ($urandom_range(0, 2) != 0) begin
                if (m_occ[fid] || $urandom_range(0, 7) == 0) fv = 1'b1;
            end
            if (gr && (fid == eid[2:0])) fv = 1'b0;
            cycle(r, rq, fv, fid);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
